// File: rtl/count_checker_pkg.sv
// rtl/count_checker_pkg.sv - shared types and constants for the counter-bank checker
package count_checker_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } chk_state_e;

    localparam int NUM_CH_DEF = 5;
    localparam int WIDTH_DEF  = 8;

    function automatic int ch_idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/count_checker_chan.sv
// rtl/count_checker_chan.sv - per-channel reference model: FSM, expected value, mismatch
module count_checker_chan
    import count_checker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_sample_valid,
    input  logic             i_chan_reset,
    input  logic [WIDTH-1:0] i_count_in,
    output logic             o_mismatch,
    output logic [WIDTH-1:0] o_golden,
    output chk_state_e       o_state
);

    chk_state_e       r_state;
    logic [WIDTH-1:0] r_exp;

    // An unsynchronised channel only checks the reset level; a free-running value is accepted as-is.
    always_comb begin
        o_mismatch = 1'b0;
        o_golden   = i_chan_reset ? '0 : r_exp;
        if (r_state == UNSYNC) begin
            o_golden   = i_chan_reset ? '0 : i_count_in;
            o_mismatch = i_sample_valid && i_chan_reset && (i_count_in != '0);
        end else begin
            o_mismatch = i_sample_valid && (i_count_in != o_golden);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= UNSYNC;
            r_exp   <= '0;
        end else if (i_clear) begin
            r_state <= UNSYNC;
            r_exp   <= '0;
        end else if (i_sample_valid) begin
            r_exp   <= i_count_in + WIDTH'(1);
            r_state <= (o_mismatch || r_state == FAULT) ? FAULT : TRACK;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - counter-bank checker top: sticky flags, error count, first-error capture
// Optional COUNT_CHECKER_ASSERT_EN fires $error on every mismatch.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ERR_CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             sample_valid,
    input  logic [NUM_CH-1:0]             chan_reset,
    input  logic [NUM_CH*WIDTH-1:0]       count_in,
    input  logic                          clear,
    output logic [NUM_CH-1:0]             synced,
    output logic [NUM_CH-1:0]             err_mask,
    output logic                          err_any,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic                          first_err_valid,
    output logic [ch_idx_w(NUM_CH)-1:0]   first_err_ch,
    output logic [WIDTH-1:0]              first_err_exp,
    output logic [WIDTH-1:0]              first_err_got
);

    localparam int IDX_W = ch_idx_w(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] w_mis;
    logic [WIDTH-1:0]  w_golden [NUM_CH];
    chk_state_e        w_state  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        count_checker_chan #(.WIDTH(WIDTH)) u_chan (
            .i_clock        (clock),
            .i_reset_n      (reset_n),
            .i_clear        (clear),
            .i_sample_valid (sample_valid[g]),
            .i_chan_reset   (chan_reset[g]),
            .i_count_in     (count_in[g*WIDTH +: WIDTH]),
            .o_mismatch     (w_mis[g]),
            .o_golden       (w_golden[g]),
            .o_state        (w_state[g])
        );
        assign synced[g] = (w_state[g] != UNSYNC);

`ifdef COUNT_CHECKER_ASSERT_EN
        always @(posedge clock) begin
            if (reset_n && !clear) begin
                assert (!w_mis[g])
                else $error("count_checker: channel %0d expected %0d observed %0d",
                            g, w_golden[g], count_in[g*WIDTH +: WIDTH]);
            end
        end
`endif
    end

    logic [CNT_W-1:0]     w_nmis;
    logic [ERR_CNT_W:0]   w_sum;
    logic [IDX_W-1:0]     w_win_ch;
    logic [WIDTH-1:0]     w_win_exp;
    logic [WIDTH-1:0]     w_win_got;

    // Descending scan so the lowest mismatching channel is the last writer and wins.
    always_comb begin
        w_nmis    = '0;
        w_win_ch  = '0;
        w_win_exp = '0;
        w_win_got = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_nmis = w_nmis + CNT_W'(w_mis[i]);
            if (w_mis[i]) begin
                w_win_ch  = IDX_W'(i);
                w_win_exp = w_golden[i];
                w_win_got = count_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sum = {1'b0, err_count} + (ERR_CNT_W+1)'(w_nmis);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_mask        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else if (clear) begin
            err_mask        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            err_mask  <= err_mask | w_mis;
            err_count <= w_sum[ERR_CNT_W] ? '1 : w_sum[ERR_CNT_W-1:0];
            if (!first_err_valid && (|w_mis)) begin
                first_err_valid <= 1'b1;
                first_err_ch    <= w_win_ch;
                first_err_exp   <= w_win_exp;
                first_err_got   <= w_win_got;
            end
        end
    end

    assign err_any = |err_mask;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - scoreboard bench for count_checker with a queue-based reference model
module tb_count_checker;

    localparam int NCH = 5;
    localparam int W   = 8;
    localparam int EW  = 16;
    localparam int MOD = 256;
    localparam int SAT = 65535;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               clear = 1'b0;
    logic [NCH-1:0]     sample_valid = '0;
    logic [NCH-1:0]     chan_reset = '0;
    logic [NCH*W-1:0]   count_in = '0;
    logic [NCH-1:0]     synced;
    logic [NCH-1:0]     err_mask;
    logic               err_any;
    logic [EW-1:0]      err_count;
    logic               first_err_valid;
    logic [2:0]         first_err_ch;
    logic [W-1:0]       first_err_exp;
    logic [W-1:0]       first_err_got;

    count_checker #(.NUM_CH(NCH), .WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .sample_valid    (sample_valid),
        .chan_reset      (chan_reset),
        .count_in        (count_in),
        .clear           (clear),
        .synced          (synced),
        .err_mask        (err_mask),
        .err_any         (err_any),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_ch    (first_err_ch),
        .first_err_exp   (first_err_exp),
        .first_err_got   (first_err_got)
    );

    always #5 clock = ~clock;

    typedef struct {
        int synced;
        int mask;
        int cnt;
        int fv;
        int fch;
        int fexp;
        int fgot;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // model: last observed value per channel (-1 = never seen since reset/clear)
    int m_last [NCH];
    int m_err  [NCH];
    int m_cnt, m_fv, m_fch, m_fexp, m_fgot;

    int d_v [NCH];
    int d_r [NCH];
    int d_c [NCH];
    int d_clr;
    int d_rn;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_last[ch] = -1;
            m_err[ch]  = 0;
        end
        m_cnt = 0; m_fv = 0; m_fch = 0; m_fexp = 0; m_fgot = 0;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.synced = 0;
        e.mask   = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_last[ch] >= 0) e.synced += (1 << ch);
            if (m_err[ch] != 0)  e.mask   += (1 << ch);
        end
        e.cnt = m_cnt; e.fv = m_fv; e.fch = m_fch; e.fexp = m_fexp; e.fgot = m_fgot;
        return e;
    endfunction

    function automatic void model_step();
        int nerr;
        int g;
        int bad;
        nerr = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (d_v[ch] != 0) begin
                if (m_last[ch] < 0) begin
                    g   = 0;
                    bad = (d_r[ch] != 0 && d_c[ch] != 0) ? 1 : 0;
                end else begin
                    g   = (d_r[ch] != 0) ? 0 : (m_last[ch] + 1) % MOD;
                    bad = (d_c[ch] != g) ? 1 : 0;
                end
                m_last[ch] = d_c[ch];
                if (bad != 0) begin
                    m_err[ch] = 1;
                    nerr++;
                    if (m_fv == 0) begin
                        m_fv = 1; m_fch = ch; m_fexp = g; m_fgot = d_c[ch];
                    end
                end
            end
        end
        m_cnt = (m_cnt + nerr > SAT) ? SAT : m_cnt + nerr;
    endfunction

    task automatic smp(input int ch, input int val, input int rst);
        d_v[ch] = 1;
        d_c[ch] = val;
        d_r[ch] = rst;
    endtask

    task automatic cycle();
        @(negedge clock);
        reset_n = d_rn[0];
        clear   = d_clr[0];
        for (int ch = 0; ch < NCH; ch++) begin
            sample_valid[ch]     = d_v[ch][0];
            chan_reset[ch]       = d_r[ch][0];
            count_in[ch*W +: W]  = W'(d_c[ch]);
        end
        if (d_rn == 0 || d_clr != 0) model_reset();
        else model_step();
        sb_q.push_back(snap());
        for (int ch = 0; ch < NCH; ch++) begin
            d_v[ch] = 0; d_r[ch] = 0; d_c[ch] = 0;
        end
        d_clr = 0;
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("synced",          int'(synced),          e.synced);
                chk("err_mask",        int'(err_mask),        e.mask);
                chk("err_any",         int'(err_any),         (e.mask != 0) ? 1 : 0);
                chk("err_count",       int'(err_count),       e.cnt);
                chk("first_err_valid", int'(first_err_valid), e.fv);
                chk("first_err_ch",    int'(first_err_ch),    e.fch);
                chk("first_err_exp",   int'(first_err_exp),   e.fexp);
                chk("first_err_got",   int'(first_err_got),   e.fgot);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int val;
        int rst;
        for (int ch = 0; ch < NCH; ch++) begin
            d_v[ch] = 0; d_r[ch] = 0; d_c[ch] = 0;
        end
        d_clr = 0;
        d_rn  = 0;
        model_reset();
        repeat (2) cycle();
        d_rn = 1;

        smp(0, 0, 0); smp(1, 5, 0);  smp(2, 254, 0); cycle();
        smp(0, 1, 0); smp(1, 6, 0);  smp(2, 255, 0); cycle();
        smp(0, 2, 0); smp(1, 9, 0);  smp(2, 0, 0);   cycle();
        smp(0, 3, 0); smp(1, 10, 0); smp(2, 1, 0);   cycle();
        d_clr = 1; cycle();
        smp(3, 3, 0); smp(4, 3, 0); cycle();
        smp(3, 7, 0); smp(4, 7, 0); cycle();
        smp(0, 7, 1); cycle();
        smp(0, 0, 1); cycle();
        smp(0, 1, 0); cycle();
        smp(0, 5, 0); d_clr = 1; cycle();
        smp(0, 0, 0); smp(1, 0, 0); cycle();
        smp(0, 9, 0); smp(1, 1, 0); cycle();

        // asynchronous reset between clock edges
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        d_rn = 0;
        model_reset();
        #1;
        chk("async_synced",    int'(synced),          0);
        chk("async_err_mask",  int'(err_mask),        0);
        chk("async_err_count", int'(err_count),       0);
        chk("async_first_vld", int'(first_err_valid), 0);
        cycle();
        d_rn = 1;
        smp(2, 0, 1); cycle();
        smp(2, 1, 0); cycle();

        for (int i = 0; i < 500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rst = ($urandom_range(0, 7) == 0) ? 1 : 0;
                    if (m_last[ch] < 0) val = (rst != 0) ? 0 : int'($urandom_range(0, 255));
                    else val = (rst != 0) ? 0 : (m_last[ch] + 1) % MOD;
                    if ($urandom_range(0, 15) == 0) val = int'($urandom_range(0, 255));
                    smp(ch, val, rst);
                end
            end
            if ($urandom_range(0, 59) == 0) d_clr = 1;
            cycle();
        end

        repeat (2) @(posedge clock);
        #2;
        chk("queue_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
